// File: rtl/fft_r4_pkg.sv
// Shared definitions for the radix-4 FFT sequencer: state encoding, defaults, index helpers.
package fft_r4_pkg;

    localparam int unsigned MAX_LOG4N_DEF = 3;
    localparam int unsigned BF_LAT_DEF    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // 4^n
    function automatic int unsigned pow4(input int unsigned n);
        return 32'd1 << (32'd2 * n);
    endfunction

    // Twiddle exponent base: (idx mod 4^(l-1-s)) << 2s; zero outside a valid stage.
    function automatic int unsigned tw_shift(input int unsigned idx,
                                             input int unsigned l,
                                             input int unsigned s);
        if (l == 32'd0 || s >= l) begin
            return 32'd0;
        end
        return (idx & (pow4(l - 32'd1 - s) - 32'd1)) << (32'd2 * s);
    endfunction

endpackage

// File: rtl/fft_r4_wb_delay.sv
// Write-back delay line: carries {valid, butterfly index} across the butterfly pipeline.
module fft_r4_wb_delay
    import fft_r4_pkg::*;
#(
    parameter int unsigned DEPTH = BF_LAT_DEF,
    parameter int unsigned W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_vld,
    input  logic [W-1:0] in_idx,
    output logic         out_vld,
    output logic [W-1:0] out_idx
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     idx_q [DEPTH];

    // Shift stage; clr empties the line so an aborted transform leaves no writes behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx_q[i] <= '0;
            end
        end else if (clr) begin
            vld_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            idx_q[0] <= in_idx;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/fft_r4_ctrl_mm.sv
// Multimode radix-4 FFT sequencer: runtime size, per-butterfly issue, pipeline drain, abort, backpressure.
module fft_r4_ctrl_mm
    import fft_r4_pkg::*;
#(
    parameter  int unsigned MAX_LOG4N = MAX_LOG4N_DEF,
    parameter  int unsigned BF_LAT    = BF_LAT_DEF,
    localparam int unsigned IDX_W     = (MAX_LOG4N > 1) ? 2 * MAX_LOG4N - 2 : 1,
    localparam int unsigned STG_W     = (MAX_LOG4N > 1) ? $clog2(MAX_LOG4N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [STG_W:0]   mode,
    input  logic             abort,
    input  logic             out_ready,
    output logic             busy,
    output logic [STG_W-1:0] stage,
    output logic             bf_enable,
    output logic [IDX_W-1:0] bf_idx,
    output logic [IDX_W-1:0] tw_addr,
    output logic             mux_sel,
    output logic             reg_we,
    output logic [IDX_W-1:0] wr_idx,
    output logic             valid,
    output logic             done,
    output logic             err_mode
);

    localparam int unsigned MODE_W = STG_W + 1;
    localparam int unsigned CNT_W  = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    state_e             state_q, state_d;
    logic [MODE_W-1:0]  l_q, l_d;
    logic [STG_W-1:0]   s_q, s_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   tw_d;
    logic               done_d;
    logic               err_d;
    logic               mode_ok;
    logic               last_idx;
    logic               last_stage;
    logic               drain_end;

    // Decodes used by the next-state logic.
    always_comb begin
        mode_ok    = (mode != '0) && (mode <= MODE_W'(MAX_LOG4N));
        last_idx   = (idx_q == IDX_W'(pow4(32'(l_q) - 32'd1) - 32'd1));
        last_stage = ((MODE_W'(s_q) + MODE_W'(1)) >= l_q);
        drain_end  = (cnt_q == CNT_W'(BF_LAT - 1));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        s_d     = s_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tw_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                s_d   = '0;
                idx_d = '0;
                if (!abort && start) begin
                    if (mode_ok) begin
                        l_d     = mode;
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                    idx_d   = '0;
                end else if (last_idx) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                    idx_d   = '0;
                end else if (drain_end) begin
                    if (last_stage) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                        s_d     = s_q + STG_W'(1);
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                    idx_d   = '0;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    s_d     = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_IDLE) begin
            tw_d = IDX_W'(tw_shift(32'(idx_d), 32'(l_d), 32'(s_d)));
        end
    end

    // State and sequencing counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs, all derived from the next state so they move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            bf_enable <= 1'b0;
            tw_addr   <= '0;
            mux_sel   <= 1'b0;
            valid     <= 1'b0;
            done      <= 1'b0;
            err_mode  <= 1'b0;
        end else begin
            busy      <= (state_d != ST_IDLE);
            bf_enable <= (state_d == ST_RUN);
            tw_addr   <= tw_d;
            mux_sel   <= (state_d != ST_IDLE) && (s_d != '0);
            valid     <= (state_d == ST_HOLD);
            done      <= done_d;
            err_mode  <= err_d;
        end
    end

    assign stage  = s_q;
    assign bf_idx = idx_q;

    fft_r4_wb_delay #(
        .DEPTH (BF_LAT),
        .W     (IDX_W)
    ) u_wb_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (abort),
        .in_vld  (bf_enable),
        .in_idx  (bf_idx),
        .out_vld (reg_we),
        .out_idx (wr_idx)
    );

endmodule

// File: tb/tb_fft_r4_ctrl_mm.sv
// Directed scoreboard bench for fft_r4_ctrl_mm (MAX_LOG4N = 3, BF_LAT = 2).
module tb_fft_r4_ctrl_mm;

    localparam int MAXL = 3;
    localparam int D    = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] mode;
    logic       abort;
    logic       out_ready;
    logic       busy;
    logic [1:0] stage;
    logic       bf_enable;
    logic [3:0] bf_idx;
    logic [3:0] tw_addr;
    logic       mux_sel;
    logic       reg_we;
    logic [3:0] wr_idx;
    logic       valid;
    logic       done;
    logic       err_mode;

    typedef struct {
        int cyc;
        int stg;
        int idx;
        int tw;
        int mux;
    } iss_t;

    typedef struct {
        int cyc;
        int idx;
    } wr_t;

    iss_t iq[$];
    wr_t  wq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   exp_valid   = 0;

    fft_r4_ctrl_mm #(
        .MAX_LOG4N (MAXL),
        .BF_LAT    (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .out_ready (out_ready),
        .busy      (busy),
        .stage     (stage),
        .bf_enable (bf_enable),
        .bf_idx    (bf_idx),
        .tw_addr   (tw_addr),
        .mux_sel   (mux_sel),
        .reg_we    (reg_we),
        .wr_idx    (wr_idx),
        .valid     (valid),
        .done      (done),
        .err_mode  (err_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] outs();
        return 32'({busy, stage, bf_enable, bf_idx, tw_addr, mux_sel,
                    reg_we, wr_idx, valid, done, err_mode});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected issue and write-back stream for one transform accepted in cycle t0.
    task automatic push_model(input int l, input int t0);
        int b;
        b = 1 << (2 * (l - 1));
        for (int s = 0; s < l; s++) begin
            for (int k = 0; k < b; k++) begin
                iss_t e;
                wr_t  w;
                e.cyc = t0 + 1 + s * (b + D) + k;
                e.stg = s;
                e.idx = k;
                e.tw  = (k % (1 << (2 * (l - 1 - s)))) << (2 * s);
                e.mux = (s != 0) ? 1 : 0;
                iq.push_back(e);
                w.cyc = e.cyc + D;
                w.idx = k;
                wq.push_back(w);
            end
        end
        exp_valid = t0 + l * (b + D) + 1;
    endtask

    // Advance one clock, sample 1 time unit later, and score any issue or write-back.
    task automatic tick();
        iss_t e;
        wr_t  w;
        @(posedge clk);
        cyc++;
        #1;
        if (bf_enable === 1'b1) begin
            check("iss_pending", 32'(iq.size() != 0), 32'(1));
            if (iq.size() != 0) begin
                e = iq.pop_front();
                check("iss_cyc", 32'(cyc), 32'(e.cyc));
                check("iss_stage", 32'(stage), 32'(e.stg));
                check("iss_idx", 32'(bf_idx), 32'(e.idx));
                check("iss_tw", 32'(tw_addr), 32'(e.tw));
                check("iss_mux", 32'(mux_sel), 32'(e.mux));
            end
        end
        if (reg_we === 1'b1) begin
            check("wr_pending", 32'(wq.size() != 0), 32'(1));
            if (wq.size() != 0) begin
                w = wq.pop_front();
                check("wr_cyc", 32'(cyc), 32'(w.cyc));
                check("wr_idx", 32'(wr_idx), 32'(w.idx));
            end
        end
    endtask

    task automatic do_start(input int l);
        mode  = 3'(l);
        start = 1'b1;
        push_model(l, cyc);
        tick();
        start = 1'b0;
        mode  = 3'd5;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_valid_cyc"}, 32'(cyc), 32'(exp_valid));
        check({tag, "_hold"}, 32'({busy, valid, done}), 32'(3'b110));
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 3'd0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("reset_outs", outs(), 32'(0));
        rst_n = 1'b1;
        tick();

        // L=2 nominal run
        do_start(2);
        wait_valid("l2");
        tick();
        check("l2_done", 32'({busy, valid, done}), 32'(3'b001));

        // Back-to-back: start sampled in the done cycle, L=1
        do_start(1);
        wait_valid("l1");
        tick();
        check("l1_done", 32'({busy, valid, done}), 32'(3'b001));
        tick();
        check("l1_done_once", 32'(done), 32'(0));

        // L=3 full size
        do_start(3);
        wait_valid("l3");
        tick();
        check("l3_done", 32'({busy, valid, done}), 32'(3'b001));
        tick();

        // Illegal modes
        mode  = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_m0", 32'({err_mode, busy, bf_enable}), 32'(3'b100));
        tick();
        check("err_m0_clr", 32'({err_mode, busy}), 32'(0));
        mode  = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_m4", 32'({err_mode, busy, bf_enable}), 32'(3'b100));
        tick();
        check("err_m4_clr", 32'({err_mode, busy}), 32'(0));

        // Backpressure in HOLD with an ignored start
        out_ready = 1'b0;
        do_start(1);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                mode  = 3'd2;
            end
            tick();
            start = 1'b0;
            check("bp_hold", 32'({busy, valid, done}), 32'(3'b110));
        end
        out_ready = 1'b1;
        tick();
        check("bp_done", 32'({busy, valid, done}), 32'(3'b001));
        tick();
        check("bp_done_once", 32'({busy, done}), 32'(0));

        // Abort at stage 1, butterfly 2
        do_start(2);
        n = 0;
        while (!(bf_enable === 1'b1 && stage == 2'd1 && bf_idx == 4'd2) && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach", 32'(bf_enable === 1'b1 && stage == 2'd1 && bf_idx == 4'd2), 32'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outs", outs(), 32'(0));
        iq.delete();
        wq.delete();
        repeat (6) tick();
        check("abort_quiet", outs(), 32'(0));

        // abort wins over start in IDLE
        abort = 1'b1;
        start = 1'b1;
        mode  = 3'd2;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_start", 32'({busy, bf_enable, err_mode}), 32'(0));
        tick();
        check("abort_start_late", 32'({busy, bf_enable}), 32'(0));

        // Full run after abort
        do_start(2);
        wait_valid("post_abort");
        tick();
        check("post_abort_done", 32'({busy, valid, done}), 32'(3'b001));
        tick();
        check("iq_empty", 32'(iq.size()), 32'(0));
        check("wq_empty", 32'(wq.size()), 32'(0));

        // Asynchronous reset mid-transform
        do_start(3);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1 check("async_rst", outs(), 32'(0));
        iq.delete();
        wq.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("after_rst", outs(), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
